// File: rtl/fpu_common_pkg.sv
// Shared types and constants for the FPU_COMMON arithmetic helpers.
package fpu_common_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} sub_ser_state_t;

   localparam int NIBBLE_W = 4;

endpackage

// File: rtl/SUB_4bit.sv
// 4-bit borrow-lookahead subtractor slice: Diff = A - B - Bin.
module SUB_4bit (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Bin,
   output logic [3:0] Diff,
   output logic       Bout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [3:1] c;

   // generate: a=0,b=1 borrows; propagate: equal bits pass the borrow on
   assign g = ~A & B;
   assign p = ~(A ^ B);

   assign c[1] = g[0] | (p[0] & Bin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Bin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & Bin);
   assign Bout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & Bin);

   assign Diff = A ^ B ^ {c[3], c[2], c[1], Bin};

endmodule

// File: rtl/sub_serial_ctrl.sv
// Serial WIDTH-bit subtractor: one nibble per clock through a shared
// SUB_4bit slice, LSB first, with valid/ready on both sides.
module sub_serial_ctrl
   import fpu_common_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_bin,
   input  logic             i_abort,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_diff,
   output logic             o_bout,
   output logic             o_zero
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   generate
      if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
         $error("sub_serial_ctrl: WIDTH must be a multiple of 4 and >= 8");
      end
   endgenerate

   sub_ser_state_t state;
   sub_ser_state_t state_nxt;

   logic [WIDTH-1:0]    a_reg;
   logic [WIDTH-1:0]    b_reg;
   logic [WIDTH-1:0]    diff_reg;
   logic [WIDTH-1:0]    diff_nxt;
   logic                borrow_reg;
   logic                zero_reg;
   logic [CW-1:0]       cnt;
   logic                last;
   logic [NIBBLE_W-1:0] slice_a;
   logic [NIBBLE_W-1:0] slice_b;
   logic [NIBBLE_W-1:0] slice_d;
   logic                slice_bout;

   assign last    = (cnt == LAST);
   assign slice_a = a_reg[NIBBLE_W*int'(cnt) +: NIBBLE_W];
   assign slice_b = b_reg[NIBBLE_W*int'(cnt) +: NIBBLE_W];

   SUB_4bit u_slice (
      .A    (slice_a),
      .B    (slice_b),
      .Bin  (borrow_reg),
      .Diff (slice_d),
      .Bout (slice_bout)
   );

   always_comb begin
      diff_nxt = diff_reg;
      diff_nxt[NIBBLE_W*int'(cnt) +: NIBBLE_W] = slice_d;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (i_valid) state_nxt = RUN;
         end
         RUN: begin
            if (i_abort)   state_nxt = IDLE;
            else if (last) state_nxt = DONE;
         end
         DONE: begin
            if (i_ready || i_abort) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         a_reg      <= '0;
         b_reg      <= '0;
         diff_reg   <= '0;
         borrow_reg <= 1'b0;
         zero_reg   <= 1'b0;
         cnt        <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (i_valid) begin
                  a_reg      <= i_a;
                  b_reg      <= i_b;
                  borrow_reg <= i_bin;
                  zero_reg   <= 1'b0;
                  cnt        <= '0;
               end
            end
            RUN: begin
               if (!i_abort) begin
                  diff_reg   <= diff_nxt;
                  borrow_reg <= slice_bout;
                  zero_reg   <= last && (diff_nxt == '0);
                  // hold on the final nibble so the counter never wraps
                  cnt        <= last ? cnt : cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_ready = (state == IDLE) && !i_rst;
   assign o_valid = (state == DONE);
   assign o_diff  = diff_reg;
   assign o_bout  = borrow_reg;
   assign o_zero  = zero_reg;

endmodule

// File: tb/tb_sub_serial_ctrl.sv
// Directed bench for sub_serial_ctrl: vector table plus corner sequences.
module tb_sub_serial_ctrl;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         valid_in = 1'b0;
   logic         ready_out;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         abort = 1'b0;
   logic         valid_out;
   logic         ready_in = 1'b1;
   logic [W-1:0] diff;
   logic         bout;
   logic         zero;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   sub_serial_ctrl #(.WIDTH(W)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (valid_in),
      .o_ready (ready_out),
      .i_a     (a),
      .i_b     (b),
      .i_bin   (bin),
      .i_abort (abort),
      .o_valid (valid_out),
      .i_ready (ready_in),
      .o_diff  (diff),
      .o_bout  (bout),
      .o_zero  (zero)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] d;
      logic         bo;
      logic         z;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // accept one op; afterwards the operand inputs are scrambled
   task automatic start(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tbin);
      check("ready_before_accept", 32'(ready_out), 32'd1);
      a = ta;
      b = tb_;
      bin = tbin;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!valid_out && cyc < 20) begin
         tick();
         cyc++;
      end
      if (!valid_out) cyc = -1;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int cyc;
      ready_in = 1'b1;
      start(v.a, v.b, v.bin);
      wait_valid(cyc);
      check({tag, "_latency"}, 32'(cyc), 32'd4);
      check({tag, "_diff"}, 32'(diff), 32'(v.d));
      check({tag, "_bout"}, 32'(bout), 32'(v.bo));
      check({tag, "_zero"}, 32'(zero), 32'(v.z));
      tick();
      check({tag, "_valid_drop"}, 32'(valid_out), 32'd0);
      check({tag, "_ready_back"}, 32'(ready_out), 32'd1);
   endtask

   initial begin
      int cyc;
      int seen;
      vecs[0]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      vecs[2]  = '{16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b1};
      vecs[3]  = '{16'h5A5A, 16'h5A5A, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[4]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b1};
      vecs[5]  = '{16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0};
      vecs[6]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0};
      vecs[7]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[8]  = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
      vecs[9]  = '{16'h0F0F, 16'hF0F0, 1'b0, 16'h1E1F, 1'b1, 1'b0};
      vecs[10] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};

      #2;
      check("rst_valid", 32'(valid_out), 32'd0);
      check("rst_ready", 32'(ready_out), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_bout", 32'(bout), 32'd0);
      check("rst_zero", 32'(zero), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("rst_release_ready", 32'(ready_out), 32'd1);
      tick();

      for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // backpressure with a stray request while holding the result
      ready_in = 1'b0;
      start(16'h8000, 16'h0001, 1'b0);
      wait_valid(cyc);
      check("bp_latency", 32'(cyc), 32'd4);
      for (int i = 0; i < 10; i++) begin
         valid_in = (i % 3 == 1);
         a = 16'h0003;
         b = 16'h0001;
         tick();
         check("bp_valid_hold", 32'(valid_out), 32'd1);
         check("bp_diff_hold", 32'(diff), 32'h7FFF);
         check("bp_ready_low", 32'(ready_out), 32'd0);
      end
      valid_in = 1'b0;
      ready_in = 1'b1;
      tick();
      check("bp_release_valid", 32'(valid_out), 32'd0);
      check("bp_release_ready", 32'(ready_out), 32'd1);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (valid_out) seen++;
      end
      check("bp_stray_ignored", 32'(seen), 32'd0);

      // reset after two RUN cycles
      start(16'h1234, 16'h0001, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(valid_out), 32'd0);
      check("mid_rst_diff", 32'(diff), 32'd0);
      check("mid_rst_bout", 32'(bout), 32'd0);
      check("mid_rst_zero", 32'(zero), 32'd0);
      check("mid_rst_ready", 32'(ready_out), 32'd0);
      tick();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (valid_out) seen++;
      end
      check("mid_rst_no_result", 32'(seen), 32'd0);
      run_vec(vecs[5], "post_rst");

      // abort in the third RUN cycle
      start(16'h4321, 16'h1111, 1'b0);
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_ready", 32'(ready_out), 32'd1);
      check("abort_valid", 32'(valid_out), 32'd0);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (valid_out) seen++;
      end
      check("abort_no_result", 32'(seen), 32'd0);
      run_vec(vecs[4], "post_abort");

      // abort and ready together in DONE count as a handoff
      ready_in = 1'b0;
      start(16'h0100, 16'h0001, 1'b0);
      wait_valid(cyc);
      check("ab_rdy_latency", 32'(cyc), 32'd4);
      check("ab_rdy_diff", 32'(diff), 32'h00FF);
      abort = 1'b1;
      ready_in = 1'b1;
      tick();
      abort = 1'b0;
      check("ab_rdy_valid", 32'(valid_out), 32'd0);
      check("ab_rdy_ready", 32'(ready_out), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
